// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, load, shifts, rotates, arithmetic shift
// right and clear, with a saturating count of shifts since the last load/clear.
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_l,
  input  logic                       sin_r,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_msb,
  output logic                       sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_shift;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    q_d      = q_q;
    is_shift = 1'b0;
    if (en) begin
      unique case (mode_sel)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = d;
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], sin_l};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {sin_r, q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_ASR: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_CLR: q_d = '0;
        default:  q_d = q_q;
      endcase
    end
  end

  // Counter saturates at WIDTH so done stays up until the next load/clear.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (mode_sel == MODE_LOAD || mode_sel == MODE_CLR) begin
        cnt_d = '0;
      end else if (is_shift && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q         = q_q;
  assign sout_msb  = q_q[WIDTH-1];
  assign sout_lsb  = q_q[0];
  assign shift_cnt = cnt_q;
  assign done      = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an arithmetic model.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] d = '0;
  logic         sin_l = 1'b0;
  logic         sin_r = 1'b0;
  logic [W-1:0] q;
  logic         sout_msb, sout_lsb, done;
  logic [$clog2(W+1)-1:0] shift_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_q     = 0;
  int m_cnt   = 0;
  bit chk_en  = 1'b0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_msb(sout_msb),
    .sout_lsb(sout_lsb), .shift_cnt(shift_cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: arithmetic on an integer word, saturating counter via min().
  task automatic model_update(input bit r, input bit e, input int md,
                              input int dv, input bit sl, input bit sr);
    int nq;
    bit shifted;
    if (r) begin
      m_q = RV;
      m_cnt = 0;
      return;
    end
    if (!e) return;
    nq = m_q;
    shifted = 1'b1;
    case (md)
      0: begin nq = m_q; shifted = 1'b0; end
      1: begin nq = dv; shifted = 1'b0; end
      2: nq = ((m_q * 2) + sl) & MASK;
      3: nq = (m_q / 2) + (sr ? (1 << (W-1)) : 0);
      4: nq = ((m_q * 2) & MASK) + (m_q / (1 << (W-1)));
      5: nq = (m_q / 2) + ((m_q % 2) << (W-1));
      6: nq = (m_q / 2) + (m_q & (1 << (W-1)));
      default: begin nq = 0; shifted = 1'b0; end
    endcase
    if (md == 1 || md == 7) m_cnt = 0;
    else if (shifted) m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
    m_q = nq;
  endtask

  task automatic step(input bit r, input bit e, input int md,
                      input int dv, input bit sl, input bit sr);
    rst = r; en = e; mode = md[2:0]; d = dv[W-1:0]; sin_l = sl; sin_r = sr;
    @(posedge clk);
    model_update(r, e, md, dv, sl, sr);
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("q", int'(q), m_q);
      check("shift_cnt", int'(shift_cnt), m_cnt);
      check("done", int'(done), int'(m_cnt == W));
      check("sout_msb", int'(sout_msb), (m_q >> (W-1)) & 1);
      check("sout_lsb", int'(sout_lsb), m_q & 1);
    end
  end

  initial begin
    @(negedge clk);
    // 1: reset
    step(1, 0, 0, 0, 0, 0);
    check("rst_q", int'(q), 'hA5);
    check("rst_cnt", int'(shift_cnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_msb", int'(sout_msb), 1);
    check("rst_lsb", int'(sout_lsb), 1);
    // 2: load then SHL x3
    step(0, 1, 1, 'h81, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 1, 0);
    check("shl_q", int'(q), 'h0F);
    check("shl_cnt", int'(shift_cnt), 3);
    step(0, 1, 1, 'h0F, 0, 0);
    check("reload_cnt", int'(shift_cnt), 0);
    // 3: ROR full word, then one past saturation
    step(0, 1, 1, 'hB4, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 5, 0, 0, 0);
    check("ror8_q", int'(q), 'hB4);
    check("ror8_done", int'(done), 1);
    step(0, 1, 5, 0, 0, 0);
    check("ror9_q", int'(q), 'h5A);
    check("ror9_cnt", int'(shift_cnt), 8);
    // 4: ASR sign replication
    step(0, 1, 1, 'h90, 0, 0);
    step(0, 1, 6, 0, 0, 0);
    step(0, 1, 6, 0, 0, 0);
    check("asr_neg", int'(q), 'hE4);
    step(0, 1, 1, 'h10, 0, 0);
    step(0, 1, 6, 0, 0, 0);
    check("asr_pos", int'(q), 'h08);
    // 5: enable low holds, then CLR
    step(0, 1, 1, 'h3C, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 7, 'hFF, 1, 1);
    check("en_hold", int'(q), 'h3C);
    step(0, 1, 7, 'hFF, 0, 0);
    check("clr_q", int'(q), 0);
    check("clr_cnt", int'(shift_cnt), 0);
    // 6: SHR x5 then reset with en and SHL active
    for (int i = 0; i < 5; i++) step(0, 1, 3, 0, 0, 1);
    check("shr_q", int'(q), 'hF8);
    check("shr_cnt", int'(shift_cnt), 5);
    step(1, 1, 2, 'h55, 1, 1);
    check("rst_mid_q", int'(q), 'hA5);
    check("rst_mid_cnt", int'(shift_cnt), 0);
    // Mode change mid-word keeps counting
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 5, 0, 0, 0);
    check("mix_cnt", int'(shift_cnt), 2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
